// File: rtl/multi_rate_clock_gen.sv
// NUM_CH divided clocks with per-channel tick strobes; divisors CLK_FREQ/rate come from one shared
// restoring divider. Define TICK_CNT_EN to add per-channel 16-bit tick counters on tick_cnt_o.
module multi_rate_clock_gen #(
  parameter int CLK_FREQ = 50000000,
  parameter int NUM_CH   = 4,
  parameter int RATE_W   = 26,
  parameter int DIV_W    = 26
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_CH-1:0]        en_i,
  input  logic [NUM_CH*RATE_W-1:0] rate_i,
  input  logic                     sync_restart_i,
  output logic [NUM_CH-1:0]        clk_out_o,
  output logic [NUM_CH-1:0]        tick_o,
  output logic [NUM_CH-1:0]        div_valid_o,
  output logic                     busy_o
`ifdef TICK_CNT_EN
  ,
  output logic [NUM_CH*16-1:0]     tick_cnt_o
`endif
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(DIV_W) + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIVIDE, S_STORE} state_t;

  state_t                        state_q, state_d;
  logic [PTR_W-1:0]              ptr_q, ptr_d, ptr_inc_s;
  logic [NUM_CH-1:0][RATE_W-1:0] rate_s, latched_q, latched_d;
  logic [RATE_W-1:0]             divisor_q, divisor_d, rem_q, rem_d;
  logic [DIV_W-1:0]              quot_q, quot_d, store_val_s;
  logic [CNT_W-1:0]              bitcnt_q, bitcnt_d;
  logic [RATE_W:0]               rem_sh_s, rem_diff_s;
  logic                          store_s, busy_q;

  logic [NUM_CH-1:0][DIV_W-1:0]  count_q, count_d, active_q, active_d, pend_div_q, pend_div_d;
  logic [NUM_CH-1:0]             pend_q, pend_d, clk_out_q, clk_out_d, tick_q, tick_d;
  logic [NUM_CH-1:0]             div_valid_q, div_valid_d, term_s, apply_s;

  assign rate_s     = rate_i;
  assign ptr_inc_s  = (ptr_q == PTR_W'(NUM_CH - 1)) ? '0 : ptr_q + PTR_W'(1);
  assign rem_sh_s   = {rem_q, quot_q[DIV_W-1]};
  assign rem_diff_s = rem_sh_s - {1'b0, divisor_q};
  // rate 0 means "stopped"; quotients below 2 cannot form a clock, so clamp them.
  assign store_val_s = (divisor_q == '0) ? '0 :
                       (quot_q < DIV_W'(2)) ? DIV_W'(2) : quot_q;

  // Scheduler next state: scan channels, run one restoring division per changed rate.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    latched_d = latched_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    bitcnt_d  = bitcnt_q;
    store_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rate_s[ptr_q] != latched_q[ptr_q]) begin
          state_d = S_LOAD;
        end else begin
          ptr_d = ptr_inc_s;
        end
      end
      S_LOAD: begin
        latched_d[ptr_q] = rate_s[ptr_q];
        divisor_d        = rate_s[ptr_q];
        rem_d            = '0;
        quot_d           = DIV_W'(CLK_FREQ);
        bitcnt_d         = '0;
        state_d          = S_DIVIDE;
      end
      S_DIVIDE: begin
        // Dividend bits shift out of quot_q's MSB while quotient bits shift in at the LSB.
        if (rem_sh_s >= {1'b0, divisor_q}) begin
          rem_d  = rem_diff_s[RATE_W-1:0];
          quot_d = {quot_q[DIV_W-2:0], 1'b1};
        end else begin
          rem_d  = rem_sh_s[RATE_W-1:0];
          quot_d = {quot_q[DIV_W-2:0], 1'b0};
        end
        if (bitcnt_q == CNT_W'(DIV_W - 1)) begin
          state_d = S_STORE;
        end else begin
          bitcnt_d = bitcnt_q + CNT_W'(1);
        end
      end
      S_STORE: begin
        store_s = 1'b1;
        ptr_d   = ptr_inc_s;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Scheduler registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      latched_q <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      bitcnt_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      latched_q <= latched_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      bitcnt_q  <= bitcnt_d;
      busy_q    <= (state_d == S_LOAD) || (state_d == S_DIVIDE);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign term_s[g]  = (count_q[g] == active_q[g] - DIV_W'(1));
    assign apply_s[g] = pend_q[g] && ((active_q[g] == '0) || term_s[g] || !en_i[g]);
  end

  // Per-channel counters; a new divisor only lands on a period boundary or while idle.
  always_comb begin
    count_d     = count_q;
    active_d    = active_q;
    pend_div_d  = pend_div_q;
    pend_d      = pend_q;
    clk_out_d   = '0;
    tick_d      = '0;
    div_valid_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sync_restart_i || !en_i[i] || (active_q[i] == '0)) begin
        count_d[i] = '0;
      end else if (term_s[i]) begin
        count_d[i]   = '0;
        tick_d[i]    = 1'b1;
        clk_out_d[i] = (count_q[i] >= (active_q[i] >> 1));
      end else begin
        count_d[i]   = count_q[i] + DIV_W'(1);
        clk_out_d[i] = (count_q[i] >= (active_q[i] >> 1));
      end
      if (apply_s[i]) begin
        active_d[i] = pend_div_q[i];
        pend_d[i]   = 1'b0;
        count_d[i]  = '0;
      end else begin
        active_d[i] = active_q[i];
      end
      if (store_s && (ptr_q == PTR_W'(i))) begin
        pend_div_d[i] = store_val_s;
        pend_d[i]     = 1'b1;
      end else begin
        pend_div_d[i] = pend_div_d[i];
      end
      div_valid_d[i] = (active_d[i] != '0);
    end
  end

  // Per-channel registers and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q     <= '0;
      active_q    <= '0;
      pend_div_q  <= '0;
      pend_q      <= '0;
      clk_out_q   <= '0;
      tick_q      <= '0;
      div_valid_q <= '0;
    end else begin
      count_q     <= count_d;
      active_q    <= active_d;
      pend_div_q  <= pend_div_d;
      pend_q      <= pend_d;
      clk_out_q   <= clk_out_d;
      tick_q      <= tick_d;
      div_valid_q <= div_valid_d;
    end
  end

  assign clk_out_o   = clk_out_q;
  assign tick_o      = tick_q;
  assign div_valid_o = div_valid_q;
  assign busy_o      = busy_q;

`ifdef TICK_CNT_EN
  logic [NUM_CH-1:0][15:0] tick_cnt_q;

  // Tick counters advance on the same edge the tick strobe rises.
  always_ff @(posedge clk_i) begin
    if (rst_i || sync_restart_i) begin
      tick_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (tick_d[i]) begin
          tick_cnt_q[i] <= tick_cnt_q[i] + 16'd1;
        end else begin
          tick_cnt_q[i] <= tick_cnt_q[i];
        end
      end
    end
  end

  assign tick_cnt_o = tick_cnt_q;
`endif

endmodule

// File: doc/multi_rate_clock_gen.md
Name: multi_rate_clock_gen

Overview:
Parametrised successor to the single-channel speed-programmable clock divider. Generates NUM_CH independent divided clocks, each with a one-cycle tick strobe. Per-channel rate is in Hz; the divisor CLK_FREQ/rate is computed by one shared iterative divider, so there is no combinational divide. New divisors take effect only at period boundaries, so outputs never glitch. Drives game-logic timing (reel spin speeds, blink rates, debounce sampling) from the board clock.

Parameters:
- CLK_FREQ, 50000000, input clock frequency in Hz; must fit in DIV_W bits.
- NUM_CH, 4, number of output channels (1..16).
- RATE_W, 26, width of each channel's rate field.
- DIV_W, 26, width of divisors, counters and quotient.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  NUM_CH  per-channel run enable.
- rate  in  NUM_CH*RATE_W  per-channel rate in Hz; channel i uses bits [i*RATE_W +: RATE_W].
- sync_restart  in  1  one-cycle pulse; phase-aligns all channels.
- clk_out  out  NUM_CH  divided clock per channel.
- tick  out  NUM_CH  one-cycle pulse at each channel's period end.
- div_valid  out  NUM_CH  channel has a nonzero active divisor.
- busy  out  1  shared divider computing.

Behaviour:
- Reset (synchronous on rst=1): all outputs 0. count, active_div, pending_div, pending flags, latched_rate all 0. Scheduler goes to IDLE with pointer 0.
- Scheduler FSM:
  - IDLE: examine channel ptr, one channel per cycle. If rate[ptr] != latched_rate[ptr], go to LOAD; else ptr++ (wrapping at NUM_CH).
  - LOAD: latch rate into latched_rate[ptr]; init the restoring divider (dividend CLK_FREQ, divisor rate). busy=1.
  - DIVIDE: exactly DIV_W cycles, one quotient bit per cycle. busy=1.
  - STORE: q = quotient. If rate==0, q=0. Else if q<2, q=2 (clamp). Write pending_div[ptr]=q; set pending[ptr]. ptr++; return to IDLE.
  - Latency from rate change to pending write: at most NUM_CH*(DIV_W+3) cycles.
  - A rate change during DIVIDE is picked up on a later scan; it is never aborted mid-computation.
- Divisor apply, per channel:
  - If pending is set and (active_div==0, or count==active_div-1, or en==0): active_div<=pending_div, pending<=0, and count<=0 on the same edge.
  - div_valid = (active_div != 0).
- Counter, per channel, when en=1 and active_div!=0:
  - count==active_div-1: count<=0 and tick<=1.
  - Otherwise: count<=count+1 and tick<=0.
  - clk_out <= (count >= active_div/2) as a registered output. Low for floor(D/2) cycles, high for ceil(D/2) cycles.
- en=0 or active_div==0: count<=0, clk_out<=0, tick<=0.
- sync_restart=1: all count<=0 and tick<=0 that cycle, clk_out<=0; pending applies still occur. Takes priority over the terminal-count tick.
- rst takes priority over everything, including mid-DIVIDE (computation discarded).
- tick period equals active_div exactly. The first tick after enable comes active_div cycles after the first counting edge.

Optional Feature:
TICK_CNT_EN
- Defined: adds output tick_cnt, NUM_CH*16 bits. Each 16-bit field increments on its channel's tick, wraps 0xFFFF->0, and clears on rst or sync_restart.
- Undefined: port and counters absent. All other behaviour identical.

Test Plan:
- CLK_FREQ=100, ch0 rate=10, en=1 after reset -> div_valid[0] within NUM_CH*(DIV_W+3) cycles. Then tick every 10 cycles; clk_out low 5 / high 5.
- ch1 rate=3 -> divisor 33; clk_out low 16 / high 17; tick period 33. ch0 unaffected.
- ch0 running at 10; set rate=20 mid-period (count=4) -> the current 10-cycle period completes, then period becomes 5; no tick gap or runt pulse.
- rate=0 -> after STORE and the boundary, div_valid=0 and clk_out/tick stay 0. rate=200 -> divisor clamps to 2, clk_out toggles every cycle.
- Two channels at rate 10 and 5, sync_restart pulsed at arbitrary offset -> next cycle both counts 0. ticks then align every 20 cycles. tick_cnt clears when TICK_CNT_EN is defined.
- rst asserted mid-DIVIDE and while outputs are high -> next cycle all outputs 0, busy=0; the computation restarts after rst deasserts.
